hf_bpf_biquad_mc: RTL
=====================

// Module: hf_bpf_biquad_mc
// PURPOSE
//  Multi-channel, time-multiplexed digital biquad band-pass section. It is the
//  parametrised successor of the fixed HF BPF test circuit and is run-time
//  configurable (per-channel coefficients, so f0/Q can differ per channel).
//  It sits between the sampled-input source and the measurement/export stage.
//  A single shared multiplier evaluates Direct Form I, one MAC term per cycle.
// PARAMETERS
//  DW    16  signed sample width (input and output)
//  CW    18  signed coefficient width
//  FRAC  14  coefficient fraction bits (1.0 = 1<<FRAC)
//  CH    4   number of channels, >=1; CHW = max(1,$clog2(CH))
//  ACCW  37  accumulator width (DW+CW+3)
// PORTS
//  clk        in   1     rising-edge clock
//  rst        in   1     asynchronous reset, active-high
//  s_valid    in   1     input sample valid
//  s_ready    out  1     block can accept a sample
//  s_data     in   DW    signed input sample
//  s_chan     in   CHW   channel of input sample
//  m_valid    out  1     output sample valid
//  m_ready    in   1     downstream accepts output
//  m_data     out  DW    signed filtered sample
//  m_chan     out  CHW   channel of output sample
//  m_sat      out  1     output was saturated
//  cfg_we     in   1     coefficient write strobe
//  cfg_chan   in   CHW   channel to write
//  cfg_idx    in   3     0=b0 1=b1 2=b2 3=a1 4=a2; 5..7 ignored
//  cfg_data   in   CW    signed coefficient
//  clr_state  in   1     zero x1,x2,y1,y2 of all channels (coefficients kept)
// BEHAVIOUR
//  Equation: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2. Accumulate at full
//   ACCW width. Add 1<<(FRAC-1), arithmetic shift right by FRAC, then
//   saturate to DW bits ([-2^(DW-1), 2^(DW-1)-1]).
//  After a sample: x2<=x1, x1<=x, y2<=y1, y1<=saturated y. This state is kept
//   per channel.
//  Reset (async): all outputs 0; s_ready=1 once reset is released.
//   Every channel: b0=1<<FRAC, b1=b2=a1=a2=0 (passthrough); all state = 0.
//  FSM states: IDLE -> MAC0..MAC4 -> OUT -> IDLE.
//   IDLE: s_ready=1. On s_valid, latch x and chan, snapshot the channel's 5
//    coefficients and 4 state words, then go to MAC0. A s_chan value >= CH is
//    dropped: it is accepted, no output, and the FSM stays in IDLE.
//   MACk: one product per cycle, term order b0,b1,b2,a1,a2.
//   OUT: m_valid=1; m_data, m_chan and m_sat are held stable until m_ready.
//    The handshake completes in the same cycle as m_ready. That cycle writes
//    the state back to the channel; the next cycle is IDLE.
//  s_ready=0 in every state except IDLE. Latency: accept edge + 6 cycles to
//   m_valid. Max throughput is 1 sample per 7 clocks when m_ready is held high.
//  cfg_we: allowed in any cycle, takes effect next cycle. A sample in flight
//   uses its snapshot, so a new coefficient applies from the next acceptance.
//  clr_state: applied in the cycle it is asserted. If in-flight, the OUT
//   write-back of that sample is suppressed, so the state stays 0. The output
//   is still produced.
//  If s_valid, cfg_we and clr_state coincide in IDLE: the accepted sample sees
//   the old coefficients and zeroed state.
//  m_sat=1 only for the sample whose value was clipped; it is not sticky.
//  Reset mid-operation: the FSM aborts to IDLE and m_valid drops immediately.
//   The in-flight sample is lost, and coefficients and state return to reset
//   values.
// TESTING
//  1 After reset, ch0 x=1000 -> m_data=1000, m_chan=0, m_valid 6 clocks after
//    accept, m_sat=0.
//  2 ch1 b0=8192, b1=4096, others 0; inputs 16000,0,0 -> outputs 8000, 4000, 0.
//  3 ch2 b0=16384, a1=-8192; step of four samples x=1000 -> outputs 1000, 1500,
//    1750, 1875.
//  4 ch3 b0=32767 (~2.0): x=30000 -> 32767 with m_sat=1; x=-30000 -> -32768
//    with m_sat=1; then x=100 -> 200 with m_sat=0.
//  5 Interleave ch0/ch2 using the config from test 3: ch0 passthrough stays
//    exact, and the ch2 step sequence is unaffected by ch0 traffic.
//  6 Hold m_ready=0 for 10 clocks: outputs stay stable and s_ready stays 0.
//    Assert rst during MAC2: m_valid=0, s_ready=1 after release, and ch2 is
//    back to passthrough.

Source files
------------

// File: rtl/hf_bpf_biquad_mc.sv
`default_nettype none
// ============================================================================
// Module   : hf_bpf_biquad_mc
// Purpose  : Multi-channel, time-multiplexed Direct Form I biquad band-pass
//            section. One shared multiplier evaluates one MAC term per cycle
//            (b0,b1,b2,a1,a2). Coefficients and x1/x2/y1/y2 history are
//            stored per channel.
// Ports    : clk, rst (async, active-high)
//            s_valid/s_ready/s_data/s_chan      sample input stream
//            m_valid/m_ready/m_data/m_chan/m_sat filtered output stream
//            cfg_we/cfg_chan/cfg_idx/cfg_data   coefficient write port
//            clr_state                          zero history of all channels
// Revision : 1.0 - initial release
// ============================================================================
module hf_bpf_biquad_mc #(
    parameter int DW   = 16,
    parameter int CW   = 18,
    parameter int FRAC = 14,
    parameter int CH   = 4,
    parameter int CHW  = (CH > 1) ? $clog2(CH) : 1,
    parameter int ACCW = DW + CW + 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    input  logic [CHW-1:0]       s_chan,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic [CHW-1:0]       m_chan,
    output logic                 m_sat,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_chan,
    input  logic [2:0]           cfg_idx,
    input  logic signed [CW-1:0] cfg_data,
    input  logic                 clr_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAC0 = 3'd1,
        S_MAC1 = 3'd2,
        S_MAC2 = 3'd3,
        S_MAC3 = 3'd4,
        S_MAC4 = 3'd5,
        S_OUT  = 3'd6
    } state_t;

    localparam int PW = DW + CW;
    localparam logic [CHW:0]             c_CH_LIM = (CHW + 1)'(CH);
    localparam logic signed [CW-1:0]     c_UNITY  = CW'(1) << FRAC;
    localparam logic signed [ACCW-1:0]   c_HALF   = ACCW'(1) << (FRAC - 1);
    localparam logic signed [ACCW-1:0]   c_YMAX   = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0]   c_YMIN   = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Per-channel storage
    logic signed [CW-1:0] r_coef [CH][5];
    logic signed [DW-1:0] r_x1 [CH];
    logic signed [DW-1:0] r_x2 [CH];
    logic signed [DW-1:0] r_y1 [CH];
    logic signed [DW-1:0] r_y2 [CH];

    // Snapshot of the sample in flight
    state_t               r_state;
    logic [CHW-1:0]       r_chan;
    logic signed [CW-1:0] r_c [5];
    logic signed [DW-1:0] r_sx, r_sx1, r_sx2, r_sy1, r_sy2;
    logic signed [ACCW-1:0] r_acc;
    logic                 r_clr_pend;

    logic                 w_s_chan_ok;
    logic                 w_cfg_ok;
    logic                 w_wb;
    logic signed [CW-1:0] w_op_c;
    logic signed [DW-1:0] w_op_d;
    logic                 w_neg;
    logic signed [PW-1:0] w_prod;
    logic signed [ACCW-1:0] w_term, w_acc_base, w_acc_next, w_rnd, w_shift;
    logic                 w_hi, w_lo;
    logic signed [DW-1:0] w_sat_data;

    assign w_s_chan_ok = ({1'b0, s_chan} < c_CH_LIM);
    assign w_cfg_ok    = ({1'b0, cfg_chan} < c_CH_LIM) && (cfg_idx < 3'd5);
    // A clear seen at any point while the sample was in flight cancels its
    // history update so the cleared state survives.
    assign w_wb        = (r_state == S_OUT) && m_ready && !r_clr_pend;
    assign s_ready     = (r_state == S_IDLE) && !rst;

    // Operand selection for the shared multiplier
    always_comb begin
        w_op_c = r_c[0];
        w_op_d = r_sx;
        w_neg  = 1'b0;
        case (r_state)
            S_MAC1: begin w_op_c = r_c[1]; w_op_d = r_sx1; end
            S_MAC2: begin w_op_c = r_c[2]; w_op_d = r_sx2; end
            S_MAC3: begin w_op_c = r_c[3]; w_op_d = r_sy1; w_neg = 1'b1; end
            S_MAC4: begin w_op_c = r_c[4]; w_op_d = r_sy2; w_neg = 1'b1; end
            default: ;
        endcase
    end

    assign w_prod     = w_op_c * w_op_d;
    assign w_term     = ACCW'(w_prod);
    assign w_acc_base = (r_state == S_MAC0) ? '0 : r_acc;
    assign w_acc_next = w_neg ? (w_acc_base - w_term) : (w_acc_base + w_term);
    assign w_rnd      = w_acc_next + c_HALF;
    assign w_shift    = w_rnd >>> FRAC;
    assign w_hi       = (w_shift > c_YMAX);
    assign w_lo       = (w_shift < c_YMIN);
    assign w_sat_data = w_hi ? c_YMAX[DW-1:0] : (w_lo ? c_YMIN[DW-1:0] : w_shift[DW-1:0]);

    // Coefficient and history memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                r_coef[c][0] <= c_UNITY;
                for (int k = 1; k < 5; k++) r_coef[c][k] <= '0;
                r_x1[c] <= '0;
                r_x2[c] <= '0;
                r_y1[c] <= '0;
                r_y2[c] <= '0;
            end
        end else begin
            if (cfg_we && w_cfg_ok) r_coef[cfg_chan][cfg_idx] <= cfg_data;
            if (clr_state) begin
                for (int c = 0; c < CH; c++) begin
                    r_x1[c] <= '0;
                    r_x2[c] <= '0;
                    r_y1[c] <= '0;
                    r_y2[c] <= '0;
                end
            end else if (w_wb) begin
                r_x2[r_chan] <= r_sx1;
                r_x1[r_chan] <= r_sx;
                r_y2[r_chan] <= r_sy1;
                r_y1[r_chan] <= m_data;
            end
        end
    end

    // Sequencer and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_chan     <= '0;
            for (int k = 0; k < 5; k++) r_c[k] <= '0;
            r_sx       <= '0;
            r_sx1      <= '0;
            r_sx2      <= '0;
            r_sy1      <= '0;
            r_sy2      <= '0;
            r_acc      <= '0;
            r_clr_pend <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_chan     <= '0;
            m_sat      <= 1'b0;
        end else begin
            if ((r_state != S_IDLE) && clr_state) r_clr_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_clr_pend <= 1'b0;
                    // Out-of-range channels are consumed without producing output.
                    if (s_valid && w_s_chan_ok) begin
                        r_sx   <= s_data;
                        r_chan <= s_chan;
                        for (int k = 0; k < 5; k++) r_c[k] <= r_coef[s_chan][k];
                        r_sx1  <= clr_state ? '0 : r_x1[s_chan];
                        r_sx2  <= clr_state ? '0 : r_x2[s_chan];
                        r_sy1  <= clr_state ? '0 : r_y1[s_chan];
                        r_sy2  <= clr_state ? '0 : r_y2[s_chan];
                        r_state <= S_MAC0;
                    end
                end
                S_MAC0: begin r_acc <= w_acc_next; r_state <= S_MAC1; end
                S_MAC1: begin r_acc <= w_acc_next; r_state <= S_MAC2; end
                S_MAC2: begin r_acc <= w_acc_next; r_state <= S_MAC3; end
                S_MAC3: begin r_acc <= w_acc_next; r_state <= S_MAC4; end
                S_MAC4: begin
                    r_acc   <= w_acc_next;
                    m_data  <= w_sat_data;
                    m_sat   <= w_hi || w_lo;
                    m_chan  <= r_chan;
                    m_valid <= 1'b1;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
